clk_div_cfg_ctrl: RTL and testbench
===================================

Name: clk_div_cfg_ctrl

Overview:
Configuration sequencer that sits directly upstream of the runtime integer clock divider (clk_int_div_simple). It accepts divider requests from a register/CSR interface and holds the divider value and initial clock level in registers, so the divider's div_i is always register-driven. It issues the divider's valid handshake, waits for the divider's settled-done indication within a programmable timeout, and reports busy, completion and sticky error status back to software.

Parameters:
DIV_VALUE_WIDTH, 32, width of divider value (output divide ratio = div + 1); must match the downstream divider.
TIMEOUT_WIDTH, 16, width of the done-wait timeout counter.
RST_DIV_VALUE, 0, reset value of div_o (0 = divider passes clk_i through).

Ports:
clk_i  in  1  block clock, same clock as the downstream divider
rst_n_i  in  1  asynchronous active-low reset
cfg_div_i  in  DIV_VALUE_WIDTH  requested divider value
cfg_init_i  in  1  requested initial output-clock level
cfg_valid_i  in  1  request valid
cfg_ready_o  out  1  request accepted when cfg_valid_i & cfg_ready_o
timeout_i  in  TIMEOUT_WIDTH  max wait cycles for div_done_i; 0 = wait forever
div_o  out  DIV_VALUE_WIDTH  registered divider value to divider div_i
clk_init_o  out  1  registered initial level to divider clk_init_i
div_valid_o  out  1  to divider div_valid_i
div_ready_i  in  1  from divider div_ready_o
div_done_i  in  1  from divider div_done_o
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse on successful completion
err_o  out  1  sticky timeout flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (async, rst_n_i low): state IDLE; div_o = RST_DIV_VALUE; clk_init_o = 0; div_valid_o = 0; busy_o = 0; done_o = 0; err_o = 0; cfg_ready_o = 1 after reset release; timer = 0.
- States: IDLE, REQ, WAIT_DONE. Encoding is defined in the package.
- IDLE: cfg_ready_o = 1. On cfg handshake at edge N, capture cfg_div_i into div_o and cfg_init_i into clk_init_o, then go to REQ. div_o and clk_init_o change only on a cfg handshake.
- REQ: div_valid_o = 1 and busy_o = 1. The first REQ cycle is N+1. div_valid_o is held until div_ready_i; on that handshake go to WAIT_DONE and clear the timer.
- WAIT_DONE: busy_o = 1 and the timer increments each cycle.
  - The divider clears its done flag on the handshake edge, so div_done_i sampled in WAIT_DONE reflects the new setting.
  - div_done_i = 1: go to IDLE with done_o = 1 for exactly one cycle, registered so it is coincident with the first IDLE cycle.
  - Timeout: timeout_i != 0 and timer == timeout_i - 1 with div_done_i = 0. Set err_o, go to IDLE, no done_o pulse.
  - div_done_i and timeout in the same cycle: success wins.
- cfg_ready_o = 0 in REQ and WAIT_DONE. Requests are not queued; the requester holds cfg_valid_i until ready.
- Timer saturates at all-ones when timeout_i = 0 (no wrap, no error).
- err_o is sticky and cleared by err_clr_i. Simultaneous set and clear: set wins. err_o does not block new requests.
- timeout_i is sampled live; software keeps it stable while busy_o = 1.
- The divider's valid handshake is always issued, even if cfg_div_i equals the current div_o (unless the optional feature below is enabled).
- Latency, success path with div_ready_i = 1: accept at N, valid handshake at N+1, WAIT_DONE from N+2.

Optional Feature:
CLK_DIV_CFG_SKIP_SAME_EN
- Defined: a request whose cfg_div_i and cfg_init_i equal the current div_o and clk_init_o, accepted while div_done_i = 1 and err_o = 0, skips REQ and WAIT_DONE. The controller stays in IDLE and pulses done_o at N+1, with no div_valid_o.
- Undefined: every accepted request runs the full REQ/WAIT_DONE sequence.

Decomposition:
- Package clk_div_cfg_pkg: state enum typedef (IDLE/REQ/WAIT_DONE) and default width constants.
- All flops use the codebase's dffr primitive.
- One sub-module, clk_div_cfg_tmo: clear/enable saturating counter plus compare against timeout_i, producing the expire pulse.

Test Plan:
- Reset: hold rst_n_i low mid-sequence (in WAIT_DONE) -> all outputs return to reset values immediately; div_o = RST_DIV_VALUE; the next request after release runs normally.
- Basic: cfg_div_i = 3, cfg_init_i = 0, valid at N with real divider attached -> div_o = 3 at N+1; div_valid_o pulse at N+1; done_o once when the divider's done counter saturates; clk_o of the divider = clk_i/4.
- Backpressure: div_ready_i held 0 for 5 cycles in REQ -> div_valid_o stays 1 for 6 cycles; cfg_valid_i with new value during that time is ignored (div_o unchanged).
- Timeout: timeout_i = 10, div_done_i tied 0 -> err_o rises on the 10th WAIT_DONE cycle, no done_o, back to IDLE. err_clr_i together with a second timeout -> err_o stays 1.
- No-timeout: timeout_i = 0, div_done_i asserted after 70000 cycles -> no err_o, done_o pulses, timer saturated without wrap.
- Skip-same (macro defined): repeat identical request after done -> done_o at N+1, div_valid_o never asserted. Macro undefined: full handshake occurs.

Source files
------------

// File: rtl/clk_div_cfg_pkg.sv
// Shared types and default widths for the divider configuration sequencer.
package clk_div_cfg_pkg;

  localparam int DEF_DIV_VALUE_WIDTH = 32;
  localparam int DEF_TIMEOUT_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQ       = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/clk_div_cfg_ctrl_if.sv
// Software request side and downstream divider side of clk_div_cfg_ctrl.
interface clk_div_cfg_ctrl_if
  import clk_div_cfg_pkg::*;
#(
  parameter int DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH,
  parameter int TIMEOUT_WIDTH   = DEF_TIMEOUT_WIDTH
);

  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i;
  logic                       cfg_init_i;
  logic                       cfg_valid_i;
  logic                       cfg_ready_o;
  logic [TIMEOUT_WIDTH-1:0]   timeout_i;
  logic [DIV_VALUE_WIDTH-1:0] div_o;
  logic                       clk_init_o;
  logic                       div_valid_o;
  logic                       div_ready_i;
  logic                       div_done_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;
  logic                       err_clr_i;

  modport slave (
    input  cfg_div_i, cfg_init_i, cfg_valid_i, timeout_i,
    input  div_ready_i, div_done_i, err_clr_i,
    output cfg_ready_o, div_o, clk_init_o, div_valid_o,
    output busy_o, done_o, err_o
  );

  modport master (
    output cfg_div_i, cfg_init_i, cfg_valid_i, timeout_i,
    output div_ready_i, div_done_i, err_clr_i,
    input  cfg_ready_o, div_o, clk_init_o, div_valid_o,
    input  busy_o, done_o, err_o
  );

endinterface

// File: rtl/clk_div_cfg_tmo.sv
// Done-wait timer: clear/enable saturating counter with timeout compare.
module clk_div_cfg_tmo
  import clk_div_cfg_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  output logic                     expire_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE = TIMEOUT_WIDTH'(1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX = '1;

  logic [TIMEOUT_WIDTH-1:0] cnt_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;

  // Saturate instead of wrapping so an infinite wait never aliases a timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = '0;
    else if (en && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  dffr #(.WIDTH(TIMEOUT_WIDTH)) u_cnt_ff (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  assign expire_o = en && (timeout_i != '0) && (cnt_q == (timeout_i - CNT_ONE));

endmodule

// File: rtl/dffr.sv
// Resettable D flop primitive: async active-low reset to RST_VAL.
module dffr #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: non-blocking so every flop samples its d before any q updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Register-driven request sequencer for the runtime clock divider.
// Optional macro CLK_DIV_CFG_SKIP_SAME_EN: skip the divider handshake for an unchanged, settled setting.
module clk_div_cfg_ctrl
  import clk_div_cfg_pkg::*;
#(
  parameter int                         DIV_VALUE_WIDTH = DEF_DIV_VALUE_WIDTH,
  parameter int                         TIMEOUT_WIDTH   = DEF_TIMEOUT_WIDTH,
  parameter logic [DIV_VALUE_WIDTH-1:0] RST_DIV_VALUE   = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  clk_div_cfg_ctrl_if.slave bus
);

  state_e                     state_d;
  state_e                     state_q;
  logic [1:0]                 state_bits_q;
  logic [DIV_VALUE_WIDTH-1:0] div_d;
  logic [DIV_VALUE_WIDTH-1:0] div_q;
  logic                       init_d;
  logic                       init_q;
  logic                       done_d;
  logic                       done_q;
  logic                       err_d;
  logic                       err_q;
  logic                       skip;
  logic                       tmr_clr;
  logic                       tmr_en;
  logic                       expire;

  assign state_q = state_e'(state_bits_q);

`ifdef CLK_DIV_CFG_SKIP_SAME_EN
  assign skip = (bus.cfg_div_i == div_q) && (bus.cfg_init_i == init_q) &&
                bus.div_done_i && !err_q;
`else
  assign skip = 1'b0;
`endif

  assign tmr_clr = (state_q == ST_REQ) && bus.div_ready_i;
  assign tmr_en  = (state_q == ST_WAIT_DONE);

  clk_div_cfg_tmo #(.TIMEOUT_WIDTH(TIMEOUT_WIDTH)) u_tmo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .timeout_i (bus.timeout_i),
    .expire_o  (expire)
  );

  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    init_d  = init_q;
    done_d  = 1'b0;
    err_d   = bus.err_clr_i ? 1'b0 : err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid_i) begin
          div_d  = bus.cfg_div_i;
          init_d = bus.cfg_init_i;
          if (skip) done_d  = 1'b1;
          else      state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.div_ready_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Success outranks a timeout landing on the same cycle; a set outranks a clear.
        if (bus.div_done_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dffr #(.WIDTH(2), .RST_VAL(ST_IDLE)) u_state_ff (
    .clk(clk_i), .rst_n(rst_n_i), .d(state_d), .q(state_bits_q)
  );
  dffr #(.WIDTH(DIV_VALUE_WIDTH), .RST_VAL(RST_DIV_VALUE)) u_div_ff (
    .clk(clk_i), .rst_n(rst_n_i), .d(div_d), .q(div_q)
  );
  dffr #(.WIDTH(1)) u_init_ff (
    .clk(clk_i), .rst_n(rst_n_i), .d(init_d), .q(init_q)
  );
  dffr #(.WIDTH(1)) u_done_ff (
    .clk(clk_i), .rst_n(rst_n_i), .d(done_d), .q(done_q)
  );
  dffr #(.WIDTH(1)) u_err_ff (
    .clk(clk_i), .rst_n(rst_n_i), .d(err_d), .q(err_q)
  );

  assign bus.cfg_ready_o = (state_q == ST_IDLE);
  assign bus.div_valid_o = (state_q == ST_REQ);
  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.div_o       = div_q;
  assign bus.clk_init_o  = init_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Randomized bench for clk_div_cfg_ctrl with a transaction-level expectation model.
`timescale 1ns/1ps
module tb_clk_div_cfg_ctrl;
  import clk_div_cfg_pkg::*;

  localparam int             DW      = 32;
  localparam int             TW      = 16;
  localparam logic [DW-1:0]  RST_DIV = '0;
  localparam int             NEVER   = 1000000;
`ifdef CLK_DIV_CFG_SKIP_SAME_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [DW-1:0] cur_div;
  logic          cur_init;
  logic          err_exp;

  clk_div_cfg_ctrl_if #(.DIV_VALUE_WIDTH(DW), .TIMEOUT_WIDTH(TW)) bus ();

  clk_div_cfg_ctrl #(
    .DIV_VALUE_WIDTH(DW), .TIMEOUT_WIDTH(TW), .RST_DIV_VALUE(RST_DIV)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset(input string name);
    vectors++; if (bus.div_o !== RST_DIV) begin miscompares++; $display("FAIL %s div_o: got %0h expected %0h", name, bus.div_o, RST_DIV); end
    vectors++; if (bus.clk_init_o !== 1'b0) begin miscompares++; $display("FAIL %s clk_init_o: got %b expected 0", name, bus.clk_init_o); end
    vectors++; if (bus.div_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s div_valid_o: got %b expected 0", name, bus.div_valid_o); end
    vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL %s busy_o: got %b expected 0", name, bus.busy_o); end
    vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL %s done_o: got %b expected 0", name, bus.done_o); end
    vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL %s err_o: got %b expected 0", name, bus.err_o); end
  endtask

  // One request from software plus an emulated divider reacting to it.
  // r: REQ cycles before div_ready_i; d: WAIT_DONE cycles before done; t: timeout_i.
  task automatic run_txn(input string name, input logic [DW-1:0] div, input logic init,
                         input int r, input int d, input int t,
                         input bit noise, input bit clr_at_expire);
    int valid_cnt = 0, busy_cnt = 0, ready_bad = 0, early_done = 0;
    int k = 0, j = 0, budget, exp_wait;
    bit phase = 0, hs_next, finished = 0, exp_skip, exp_ok;

    exp_skip = SKIP_EN && (div == cur_div) && (init == cur_init) &&
               (bus.div_done_i === 1'b1) && !err_exp;
    exp_ok   = (t == 0) || (d <= t - 1);
    exp_wait = exp_ok ? d + 1 : t;
    budget   = r + exp_wait + 8;

    @(negedge clk);
    vectors++; if (bus.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL %s cfg_ready_idle: got %b expected 1", name, bus.cfg_ready_o); end
    bus.timeout_i   = TW'(t);
    bus.cfg_div_i   = div;
    bus.cfg_init_i  = init;
    bus.cfg_valid_i = 1'b1;
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    cur_div  = div;
    cur_init = init;
    vectors++; if (bus.div_o !== div) begin miscompares++; $display("FAIL %s div_o_capture: got %0h expected %0h", name, bus.div_o, div); end
    vectors++; if (bus.clk_init_o !== init) begin miscompares++; $display("FAIL %s clk_init_capture: got %b expected %b", name, bus.clk_init_o, init); end

    if (exp_skip) begin
      vectors++; if (bus.done_o !== 1'b1) begin miscompares++; $display("FAIL %s skip_done: got %b expected 1", name, bus.done_o); end
      vectors++; if (bus.div_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s skip_valid: got %b expected 0", name, bus.div_valid_o); end
      vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL %s skip_busy: got %b expected 0", name, bus.busy_o); end
      @(negedge clk);
      vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL %s skip_done_width: got %b expected 0", name, bus.done_o); end
      return;
    end

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (!bus.busy_o) begin
        finished = 1;
      end else begin
        if (bus.div_valid_o) valid_cnt++;
        busy_cnt++;
        if (bus.cfg_ready_o) ready_bad++;
        if (bus.done_o) early_done++;
        hs_next = 0;
        if (!phase) begin
          bus.div_ready_i = (k >= r);
          hs_next = (k >= r) && bus.div_valid_o;
          if (noise) begin
            bus.cfg_valid_i = 1'b1;
            bus.cfg_div_i   = $urandom;
            bus.cfg_init_i  = 1'($urandom_range(0, 1));
          end
          k++;
        end else begin
          bus.div_ready_i = 1'b0;
          bus.cfg_valid_i = 1'b0;
          bus.div_done_i  = (j >= d);
          bus.err_clr_i   = clr_at_expire && (t != 0) && (j == t - 1);
          j++;
        end
        @(negedge clk);
        if (hs_next) phase = 1;
      end
    end
    bus.div_ready_i = 1'b0;
    bus.cfg_valid_i = 1'b0;
    bus.err_clr_i   = 1'b0;

    if (!exp_ok) err_exp = 1'b1;
    else if (clr_at_expire && (t != 0) && (d == t - 1)) err_exp = 1'b0;

    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL %s return_to_idle: busy_o still %b after %0d cycles", name, bus.busy_o, budget);
    end else begin
      vectors++; if (valid_cnt != r + 1) begin miscompares++; $display("FAIL %s div_valid_cycles: got %0d expected %0d", name, valid_cnt, r + 1); end
      vectors++; if (busy_cnt != r + 1 + exp_wait) begin miscompares++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, r + 1 + exp_wait); end
      vectors++; if (ready_bad != 0) begin miscompares++; $display("FAIL %s cfg_ready_busy: got %0d cycles expected 0", name, ready_bad); end
      vectors++; if (early_done != 0) begin miscompares++; $display("FAIL %s done_while_busy: got %0d cycles expected 0", name, early_done); end
      vectors++; if (bus.done_o !== exp_ok) begin miscompares++; $display("FAIL %s done_pulse: got %b expected %b", name, bus.done_o, exp_ok); end
      vectors++; if (bus.div_o !== div) begin miscompares++; $display("FAIL %s div_o_held: got %0h expected %0h", name, bus.div_o, div); end
      vectors++; if (bus.err_o !== err_exp) begin miscompares++; $display("FAIL %s err_o: got %b expected %b", name, bus.err_o, err_exp); end
      @(negedge clk);
      vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL %s done_width: got %b expected 0", name, bus.done_o); end
    end
  endtask

  task automatic test_basic();
    run_txn("basic", 32'd3, 1'b0, 0, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 32'h0000_00a5, 1'b1, 5, 3, 0, 1'b1, 1'b0);
  endtask

  task automatic test_err_clr();
    @(negedge clk);
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    err_exp = 1'b0;
    vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b expected 0", bus.err_o); end
  endtask

  task automatic test_timeout();
    bus.div_done_i = 1'b0;
    run_txn("timeout", 32'd9, 1'b0, 1, NEVER, 10, 1'b0, 1'b0);
    run_txn("timeout_clr_race", 32'd12, 1'b1, 0, NEVER, 10, 1'b0, 1'b1);
    run_txn("done_beats_timeout", 32'd5, 1'b0, 0, 6, 7, 1'b0, 1'b0);
    test_err_clr();
  endtask

  task automatic test_skip_same();
    run_txn("skip_prime", 32'd7, 1'b1, 0, 2, 0, 1'b0, 1'b0);
    run_txn("skip_same", 32'd7, 1'b1, 1, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] div;
    logic          init;
    int            t;
    for (int n = 0; n < 24; n++) begin
      div  = ($urandom_range(0, 3) == 0) ? cur_div  : DW'($urandom);
      init = ($urandom_range(0, 3) == 0) ? cur_init : 1'($urandom_range(0, 1));
      t    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
      run_txn("random", div, init, int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
              t, 1'($urandom_range(0, 1)), 1'b0);
      if (err_exp && ($urandom_range(0, 1) == 1)) test_err_clr();
    end
  endtask

  task automatic test_reset_mid();
    bus.div_done_i = 1'b0;
    @(negedge clk);
    bus.timeout_i   = '0;
    bus.cfg_div_i   = 32'h55;
    bus.cfg_init_i  = 1'b1;
    bus.cfg_valid_i = 1'b1;
    @(negedge clk);
    bus.cfg_valid_i = 1'b0;
    bus.div_ready_i = 1'b1;
    @(negedge clk);
    bus.div_ready_i = 1'b0;
    vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL reset_mid busy_before: got %b expected 1", bus.busy_o); end
    rst_n = 1'b0;
    #1;
    test_reset("reset_mid");
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    cur_div  = RST_DIV;
    cur_init = 1'b0;
    err_exp  = 1'b0;
    run_txn("post_reset", 32'h1234, 1'b0, 2, 3, 8, 1'b0, 1'b0);
  endtask

  task automatic test_no_timeout();
    run_txn("no_timeout", 32'd2, 1'b0, 0, 70000, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.cfg_div_i   = '0;
    bus.cfg_init_i  = 1'b0;
    bus.cfg_valid_i = 1'b0;
    bus.timeout_i   = '0;
    bus.div_ready_i = 1'b0;
    bus.div_done_i  = 1'b0;
    bus.err_clr_i   = 1'b0;
    cur_div  = RST_DIV;
    cur_init = 1'b0;
    err_exp  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset("reset");
    vectors++; if (bus.cfg_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset cfg_ready_o: got %b expected 1", bus.cfg_ready_o); end

    test_basic();
    test_backpressure();
    test_timeout();
    test_skip_same();
    test_random();
    test_reset_mid();
    test_no_timeout();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
